hlsm_operand_sequencer: RTL and testbench

Front-end stage that feeds the HLSM datapath block (inputs a, b, c; outputs z, x; Start/Done handshake). Operand triples arrive on a valid/ready stream and are buffered in a small FIFO. The block issues one Start per triple, watches Done, and captures z/x into a result slot presented on a valid/ready output stream. A watchdog flags a result as erroneous if Done never arrives.

---
 rtl/hlsm_operand_sequencer.sv | 161 ++++++++++++++++
 tb/tb_hlsm_operand_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hlsm_operand_sequencer.sv
// hlsm_operand_sequencer: operand FIFO, one-shot Start/Done sequencing
// and a result slot with a Done watchdog in front of the HLSM datapath.
module hlsm_operand_sequencer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [WIDTH-1:0]       in_c,
    output logic                   hs_Start,
    output logic [WIDTH-1:0]       hs_a,
    output logic [WIDTH-1:0]       hs_b,
    output logic [WIDTH-1:0]       hs_c,
    input  logic                   hs_Done,
    input  logic [WIDTH-1:0]       hs_z,
    input  logic [WIDTH-1:0]       hs_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_z,
    output logic [WIDTH-1:0]       out_x,
    output logic                   out_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [WIDTH-1:0] mem_c [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [TW-1:0]    timer;
    logic             done_q;

    logic push;
    logic pop;
    logic rise;
    logic cap_ok;
    logic cap_err;
    logic drain;

    assign in_ready = (fifo_count < CW'(DEPTH)) && !Rst;
    assign push     = in_valid && in_ready;
    assign rise     = hs_Done && !done_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        cap_ok  = 1'b0;
        cap_err = 1'b0;
        drain   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_count != '0 && !out_valid) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A fresh Done edge beats the watchdog on the same cycle
                if (rise) begin
                    cap_ok  = 1'b1;
                    state_d = HOLD;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    cap_err = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    drain   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Storage needs no reset; push is already gated by Rst via in_ready
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
            mem_c[wr_ptr] <= in_c;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            done_q     <= 1'b0;
            hs_Start   <= 1'b0;
            hs_a       <= '0;
            hs_b       <= '0;
            hs_c       <= '0;
            timer      <= '0;
            out_valid  <= 1'b0;
            out_z      <= '0;
            out_x      <= '0;
            out_err    <= 1'b0;
        end else begin
            done_q   <= hs_Done;
            hs_Start <= pop;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                hs_a   <= mem_a[rd_ptr];
                hs_b   <= mem_b[rd_ptr];
                hs_c   <= mem_c[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (state_q == ISSUE)     timer <= '0;
            else if (state_q == WAIT) timer <= timer + TW'(1);
            if (cap_ok) begin
                out_z     <= hs_z;
                out_x     <= hs_x;
                out_err   <= 1'b0;
                out_valid <= 1'b1;
            end else if (cap_err) begin
                out_z     <= '0;
                out_x     <= '0;
                out_err   <= 1'b1;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hlsm_operand_sequencer.sv
// Bench for hlsm_operand_sequencer: directed vector table, corner sequences
// and a randomized run scored against a queue-based reference.
module tb_hlsm_operand_sequencer;

    localparam int W  = 32;
    localparam int TO = 16;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b, in_c;
    logic          hs_Start;
    logic [W-1:0]  hs_a, hs_b, hs_c;
    logic          hs_Done;
    logic [W-1:0]  hs_z, hs_x;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_z, out_x;
    logic          out_err;
    logic          busy;
    logic [2:0]    fifo_count;

    hlsm_operand_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .hs_Start(hs_Start), .hs_a(hs_a), .hs_b(hs_b), .hs_c(hs_c),
        .hs_Done(hs_Done), .hs_z(hs_z), .hs_x(hs_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_x(out_x), .out_err(out_err),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Companion datapath behaviour: z = max(a+b, a+c), x = b*c - (a+b)
    function automatic logic [31:0] fz(logic [31:0] a, logic [31:0] b,
                                       logic [31:0] c);
        logic [31:0] d, e;
        d = a + b;
        e = a + c;
        return (d > e) ? d : e;
    endfunction

    function automatic logic [31:0] fx(logic [31:0] a, logic [31:0] b,
                                       logic [31:0] c);
        return b * c - (a + b);
    endfunction

    // Randomized-mode response delay: 0 means Done never comes
    function automatic int rdelay(logic [31:0] a, logic [31:0] b);
        if (a[3:0] == 4'h0) return 0;
        return 1 + int'(b % 17);
    endfunction

    // HLSM model: Done rises k edges after it samples Start
    logic [31:0] la, lb, lc;
    logic        hl_done;
    logic [31:0] hl_z, hl_x;
    int          hl_cnt;
    int          hl_delay = 5;
    bit          hl_stale = 0;
    bit          hl_rand  = 0;

    assign hs_Done = hl_done;
    assign hs_z    = hl_z;
    assign hs_x    = hl_x;

    always @(posedge Clk) begin
        if (Rst) begin
            hl_done <= 1'b0;
            hl_cnt  <= 0;
            hl_z    <= '0;
            hl_x    <= '0;
        end else if (hs_Start) begin
            la     <= hs_a;
            lb     <= hs_b;
            lc     <= hs_c;
            hl_cnt <= hl_rand ? rdelay(hs_a, hs_b) : hl_delay;
            if (!hl_stale) hl_done <= 1'b0;
        end else if (hl_cnt != 0) begin
            hl_cnt <= hl_cnt - 1;
            if (hl_cnt == 3) hl_done <= 1'b0;
            if (hl_cnt == 1) begin
                hl_done <= 1'b1;
                hl_z    <= fz(la, lb, lc);
                hl_x    <= fx(la, lb, lc);
            end
        end
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } trip_t;

    trip_t expq[$];
    bit    sb_on      = 0;
    int    start_cnt  = 0;
    int    res_cnt    = 0;
    int    max_cnt    = 0;
    bit    prev_start = 0;

    // Scoreboard: results must emerge in push order with model values
    always @(negedge Clk) begin
        trip_t t;
        int    k;
        bit    e;
        if (hs_Start) begin
            start_cnt++;
            check("start_pulse_width", 32'(prev_start), 32'd0);
        end
        prev_start = hs_Start;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (sb_on && !Rst) begin
            if (in_valid && in_ready) expq.push_back({in_a, in_b, in_c});
            if (out_valid && out_ready) begin
                res_cnt++;
                check("sb_queue_nonempty", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    t = expq.pop_front();
                    k = rdelay(t.a, t.b);
                    e = (k == 0) || (k > TO - 1);
                    check("sb_err", 32'(out_err), 32'(e));
                    check("sb_z", out_z, e ? 32'd0 : fz(t.a, t.b, t.c));
                    check("sb_x", out_x, e ? 32'd0 : fx(t.a, t.b, t.c));
                end
            end
        end
    end

    typedef struct {
        logic [31:0] a, b, c;
        int          k;
        bit          stale;
        logic [31:0] z, x;
        bit          err;
        int          lat;
    } vec_t;

    vec_t vt[9];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_one(input vec_t v, input string tag);
        int lat;
        int s0;
        hl_rand   = 0;
        hl_delay  = v.k;
        hl_stale  = v.stale;
        out_ready = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_c      = v.c;
        in_valid  = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        s0 = start_cnt;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_z"}, out_z, v.z);
        check({tag, "_x"}, out_x, v.x);
        check({tag, "_err"}, 32'(out_err), 32'(v.err));
        check({tag, "_starts"}, start_cnt - s0, 32'd1);
        step();
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_z_held"}, out_z, v.z);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        step();
        step();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((expq.size() != 0 || fifo_count != 0 || busy || out_valid)
               && n < 600) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(expq.size()), 32'd0);
        check({tag, "_drain_idle"}, 32'(busy), 32'd0);
    endtask

    trip_t ft[6];

    initial begin
        int    n;
        int    acc;
        int    s0;
        int    r0;
        int    ov_seen;
        int    pushed;
        bit    rdy;
        trip_t t;

        vt[0] = '{32'd3, 32'd4, 32'd5, 5, 0, 32'd8, 32'd13, 0, 8};
        vt[1] = '{32'd10, 32'd1, 32'd2, 5, 0, 32'd12, 32'hFFFF_FFF7, 0, 8};
        vt[2] = '{32'd5, 32'd9, 32'd1, 1, 0, 32'd14, 32'hFFFF_FFFB, 0, 4};
        vt[3] = '{32'd100, 32'd200, 32'd3, 15, 0, 32'd300, 32'd300, 0, 18};
        vt[4] = '{32'd7, 32'd7, 32'd7, 16, 0, 32'd0, 32'd0, 1, 18};
        vt[5] = '{32'd1, 32'd2, 32'd3, 0, 0, 32'd0, 32'd0, 1, 18};
        vt[6] = '{32'd0, 32'd0, 32'd0, 3, 0, 32'd0, 32'd0, 0, 6};
        vt[7] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 2, 0, 32'hFFFF_FFFF, 32'd0, 0, 5};
        vt[8] = '{32'd2, 32'd3, 32'd4, 8, 1, 32'd6, 32'd7, 0, 11};

        ft[0] = '{32'h1, 32'd4, 32'd9};
        ft[1] = '{32'h2, 32'd1, 32'd11};
        ft[2] = '{32'h3, 32'd7, 32'd2};
        ft[3] = '{32'h10, 32'd3, 32'd5};
        ft[4] = '{32'h5, 32'd16, 32'd6};
        ft[5] = '{32'h6, 32'd0, 32'd8};

        Rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(hs_Start), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_z", out_z, 32'd0);
        check("rst_hs_a", hs_a, 32'd0);
        Rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        for (int i = 0; i < 9; i++) run_one(vt[i], $sformatf("vec%0d", i));

        // Reset three cycles after Start with two triples still queued
        hl_rand = 0; hl_delay = 5; hl_stale = 0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 32'(i + 20); in_b = 32'd1; in_c = 32'd2;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("rstmid_count_before", 32'(fifo_count), 32'd2);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        step();
        step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        check("rstmid_count", 32'(fifo_count), 32'd0);
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_start", 32'(hs_Start), 32'd0);
        check("rstmid_hs_a", hs_a, 32'd0);
        ov_seen = 0;
        s0 = start_cnt;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) ov_seen++;
            step();
        end
        check("rstmid_no_result", ov_seen, 32'd0);
        check("rstmid_no_start", start_cnt - s0, 32'd0);
        run_one(vt[0], "after_rst");

        // Full FIFO behind a held result
        sb_on = 1; hl_rand = 1; hl_stale = 0; out_ready = 1'b0;
        {in_a, in_b, in_c} = ft[0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin step(); n++; end
        check("fifo_first_held", 32'(out_valid), 32'd1);
        s0 = start_cnt;
        max_cnt = 0;
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8 && acc < 5; i++) begin
            {in_a, in_b, in_c} = ft[1 + acc];
            rdy = in_ready;
            step();
            if (rdy) acc++;
        end
        check("fifo_accepted", acc, 32'd4);
        check("fifo_full_ready", 32'(in_ready), 32'd0);
        check("fifo_full_count", 32'(fifo_count), 32'd4);
        check("fifo_single_start", start_cnt - s0, 32'd0);
        out_ready = 1'b1;
        {in_a, in_b, in_c} = ft[5];
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 40) begin
            rdy = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        check("fifo_fifth_accepted", 32'(rdy), 32'd1);
        check("fifo_peak", max_cnt, 32'd4);
        wait_drain("fifo");

        // Simultaneous push and pop at count 2 across several pointer wraps
        hl_rand = 1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 32'(i * 2 + 1); in_b = 32'(i); in_c = 32'(i + 40);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("pp_preload", 32'(fifo_count), 32'd2);
        for (int r = 0; r < 12; r++) begin
            n = 0;
            while (!(busy == 1'b0 && !out_valid && fifo_count != 0) && n < 40) begin
                step();
                n++;
            end
            t.a = $urandom | 32'h1;
            t.b = 32'($urandom_range(0, 12));
            t.c = $urandom;
            {in_a, in_b, in_c} = t;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("pp_count_%0d", r), 32'(fifo_count), 32'd2);
            check($sformatf("pp_start_%0d", r), 32'(hs_Start), 32'd1);
        end
        wait_drain("pushpop");

        // Randomized traffic with random consumer back-pressure
        s0 = start_cnt;
        r0 = res_cnt;
        pushed = 0;
        n = 0;
        while ((pushed < 40 || expq.size() != 0 || busy || out_valid
                || fifo_count != 0) && n < 3000) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (pushed < 40) begin
                in_valid = $urandom_range(0, 1);
                in_a = $urandom;
                if ($urandom_range(0, 5) == 0) in_a[3:0] = 4'h0;
                in_b = $urandom;
                in_c = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_valid && in_ready;
            step();
            if (rdy) pushed++;
            n++;
        end
        in_valid = 1'b0;
        check("rand_all_pushed", pushed, 32'd40);
        check("rand_queue_empty", 32'(expq.size()), 32'd0);
        check("rand_results", res_cnt - r0, 32'd40);
        check("rand_starts", start_cnt - s0, 32'd40);
        sb_on = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
